// File: rtl/execute_pipe.sv
// LEGv8 execute stage: ALU + branch-target adder feeding a registered EX/MEM
// slot, with a one-bit-per-cycle shift-add multiplier that stalls the stage.
module execute_pipe #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_in,
   output logic         ready_out,
   input  logic         flush,
   input  logic         stall_in,
   input  logic         AluSrc,
   input  logic [3:0]   AluControl,
   input  logic [N-1:0] PC_E,
   input  logic [N-1:0] signImm_E,
   input  logic [N-1:0] readData1_E,
   input  logic [N-1:0] readData2_E,
   output logic         valid_out,
   output logic [N-1:0] PCBranch_M,
   output logic [N-1:0] aluResult_M,
   output logic [N-1:0] writeData_M,
   output logic         zero_M,
   output logic         busy
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_MUL  = 4'b1000;

   typedef enum logic [1:0] {IDLE, MUL, DONE_WAIT} state_t;

   state_t         state;
   logic [N-1:0]   b_op, alu_res, pc_branch;
   logic [N-1:0]   mul_a, mul_b, acc, acc_next, fin;
   logic [N-1:0]   mul_pcb, mul_wd;
   logic [CW-1:0]  count;
   logic           accept;

   assign ready_out = !reset && !busy && !(valid_out && stall_in);
   assign accept    = valid_in && ready_out;

   always_comb begin
      b_op      = AluSrc ? signImm_E : readData2_E;
      pc_branch = PC_E + (signImm_E << 2);
      alu_res   = '0;
      case (AluControl)
         OP_AND:  alu_res = readData1_E & b_op;
         OP_OR:   alu_res = readData1_E | b_op;
         OP_ADD:  alu_res = readData1_E + b_op;
         OP_SUB:  alu_res = readData1_E - b_op;
         OP_PASS: alu_res = b_op;
         OP_NOR:  alu_res = ~(readData1_E | b_op);
         default: alu_res = '0;
      endcase
   end

   // mul_a is pre-shifted and mul_b shifted down each step, so bit `count`
   // of the original B is always mul_b[0] and A<<count is always mul_a.
   always_comb begin
      acc_next = acc + (mul_b[0] ? mul_a : '0);
      fin      = (state == DONE_WAIT) ? acc : acc_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         valid_out   <= 1'b0;
         PCBranch_M  <= '0;
         aluResult_M <= '0;
         writeData_M <= '0;
         zero_M      <= 1'b0;
         mul_a       <= '0;
         mul_b       <= '0;
         acc         <= '0;
         mul_pcb     <= '0;
         mul_wd      <= '0;
         count       <= '0;
      end else if (flush) begin
         state     <= IDLE;
         busy      <= 1'b0;
         valid_out <= 1'b0;
         count     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && AluControl == OP_MUL) begin
                  mul_a       <= readData1_E;
                  mul_b       <= b_op;
                  mul_pcb     <= pc_branch;
                  mul_wd      <= readData2_E;
                  acc         <= '0;
                  count       <= '0;
                  busy        <= 1'b1;
                  state       <= MUL;
                  valid_out   <= 1'b0;
                  PCBranch_M  <= '0;
                  aluResult_M <= '0;
                  writeData_M <= '0;
                  zero_M      <= 1'b0;
               end else if (accept) begin
                  PCBranch_M  <= pc_branch;
                  aluResult_M <= alu_res;
                  writeData_M <= readData2_E;
                  zero_M      <= (alu_res == '0);
                  valid_out   <= 1'b1;
               end else if (!stall_in) begin
                  valid_out <= 1'b0;
               end
            end
            MUL: begin
               acc   <= acc_next;
               mul_a <= mul_a << 1;
               mul_b <= mul_b >> 1;
               if (count != LAST) begin
                  count <= count + CW'(1);
               end else if (stall_in) begin
                  state <= DONE_WAIT;
               end else begin
                  PCBranch_M  <= mul_pcb;
                  aluResult_M <= fin;
                  writeData_M <= mul_wd;
                  zero_M      <= (fin == '0);
                  valid_out   <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            DONE_WAIT: begin
               if (!stall_in) begin
                  PCBranch_M  <= mul_pcb;
                  aluResult_M <= fin;
                  writeData_M <= mul_wd;
                  zero_M      <= (fin == '0);
                  valid_out   <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_pipe.sv
// Randomized scoreboard bench for execute_pipe: driver pushes model results on
// accept, an independent monitor compares each presented EX/MEM result.
module tb_execute_pipe;

   localparam int N = 64;

   logic         clk = 1'b0;
   logic         reset, valid_in, flush, stall_in, AluSrc;
   logic [3:0]   AluControl;
   logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;
   logic         ready_out, valid_out, zero_M, busy;
   logic [N-1:0] PCBranch_M, aluResult_M, writeData_M;

   typedef struct packed {
      logic [N-1:0] alu;
      logic [N-1:0] pcb;
      logic [N-1:0] wd;
      logic         z;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   execute_pipe #(.N(N)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
      .flush(flush), .stall_in(stall_in), .AluSrc(AluSrc), .AluControl(AluControl),
      .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(readData1_E),
      .readData2_E(readData2_E), .valid_out(valid_out), .PCBranch_M(PCBranch_M),
      .aluResult_M(aluResult_M), .writeData_M(writeData_M), .zero_M(zero_M),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [3:0] ctl, input logic src,
                                  input logic [N-1:0] pc, imm, a, rd2);
      exp_t r;
      logic [N-1:0] b;
      b = src ? imm : rd2;
      case (ctl)
         4'b0000: r.alu = a & b;
         4'b0001: r.alu = a | b;
         4'b0010: r.alu = a + b;
         4'b0110: r.alu = a - b;
         4'b0111: r.alu = b;
         4'b1100: r.alu = ~(a | b);
         4'b1000: r.alu = a * b;
         default: r.alu = '0;
      endcase
      r.pcb = pc + imm * 4;
      r.wd  = rd2;
      r.z   = (r.alu == 0);
      return r;
   endfunction

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // One cycle of stimulus: drive at negedge, then record what the coming
   // edge will do to the expected-result queue.
   task automatic drive(input logic rs, input logic vi, input logic [3:0] ctl,
                        input logic src, input logic [N-1:0] pc, imm, a, rd2,
                        input logic st, input logic fl);
      @(negedge clk);
      reset = rs; valid_in = vi; AluControl = ctl; AluSrc = src;
      PC_E = pc; signImm_E = imm; readData1_E = a; readData2_E = rd2;
      stall_in = st; flush = fl;
      #1;
      if (rs) q.delete();
      else if (fl) begin
         if ((busy || valid_out) && q.size() > 0) void'(q.pop_front());
      end else if (vi && ready_out) q.push_back(model(ctl, src, pc, imm, a, rd2));
   endtask

   task automatic idle(input logic st = 1'b0);
      drive(1'b0, 1'b0, 4'b0000, 1'b0, '0, '0, '0, '0, st, 1'b0);
   endtask

   // Monitor: every cycle the slot shows a result it must match the oldest
   // expected entry; the entry retires when the result is not stalled.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset && !flush && valid_out) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result act=%h exp=none", aluResult_M);
            end else begin
               chk("sb_alu", aluResult_M, q[0].alu);
               chk("sb_pcb", PCBranch_M, q[0].pcb);
               chk("sb_wd", writeData_M, q[0].wd);
               chk("sb_zero", N'(zero_M), N'(q[0].z));
               if (!stall_in) void'(q.pop_front());
            end
         end
      end
   end

   logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                            4'b1100, 4'b1000, 4'b0101, 4'b0011, 4'b1111};

   initial begin
      reset = 1'b1; valid_in = 1'b0; flush = 1'b0; stall_in = 1'b0; AluSrc = 1'b0;
      AluControl = '0; PC_E = '0; signImm_E = '0; readData1_E = '0; readData2_E = '0;

      // reset state
      drive(1'b1, 1'b1, 4'b0010, 1'b0, '0, '0, 64'd1, 64'd1, 1'b0, 1'b0);
      chk("rst_ready", N'(ready_out), '0);
      drive(1'b1, 1'b1, 4'b0010, 1'b0, '0, '0, 64'd1, 64'd1, 1'b0, 1'b0);
      chk("rst_ready2", N'(ready_out), '0);
      chk("rst_flags", N'({valid_out, busy, zero_M}), '0);
      chk("rst_data", aluResult_M | PCBranch_M | writeData_M, '0);

      // ADD 5+7, PC 0x100, imm 3
      drive(1'b0, 1'b1, 4'b0010, 1'b0, 64'h100, 64'd3, 64'd5, 64'd7, 1'b0, 1'b0);
      idle();
      chk("add_valid", N'(valid_out), 64'd1);
      chk("add_alu", aluResult_M, 64'd12);
      chk("add_pcb", PCBranch_M, 64'h10C);
      chk("add_wd", writeData_M, 64'd7);
      chk("add_zero", N'(zero_M), '0);

      // SUB 9-imm 9 then undefined code
      drive(1'b0, 1'b1, 4'b0110, 1'b1, 64'h40, 64'd9, 64'd9, 64'd2, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 4'b0101, 1'b0, 64'h44, 64'd1, 64'd3, 64'd4, 1'b0, 1'b0);
      chk("sub_zero", {aluResult_M[N-2:0], zero_M}, 64'd1);
      idle();
      chk("undef_zero", {aluResult_M[N-2:0], zero_M}, 64'd1);

      // MUL all-ones x 3: exact latency and busy/ready window
      drive(1'b0, 1'b1, 4'b1000, 1'b0, 64'h200, 64'd1, '1, 64'd3, 1'b0, 1'b0);
      for (int i = 1; i <= N; i++) begin
         idle();
         chk($sformatf("mul_busy%0d", i), N'({busy, ready_out, valid_out}), 64'b100);
      end
      idle();
      chk("mul_done", N'({busy, valid_out}), 64'b01);
      chk("mul_alu", aluResult_M, 64'hFFFF_FFFF_FFFF_FFFD);

      // ADD/OR/AND back-to-back, OR result stalled 3 cycles
      drive(1'b0, 1'b1, 4'b0010, 1'b0, 64'h10, 64'd1, 64'd20, 64'd22, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 4'b0001, 1'b0, 64'h14, 64'd2, 64'h0F0, 64'h00F, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 4'b0000, 1'b0, 64'h18, 64'd3, 64'hFF, 64'h3C, 1'b1, 1'b0);
         chk($sformatf("stall_ready%0d", i), N'(ready_out), '0);
         chk($sformatf("stall_hold%0d", i), aluResult_M, 64'h0FF);
      end
      drive(1'b0, 1'b1, 4'b0000, 1'b0, 64'h18, 64'd3, 64'hFF, 64'h3C, 1'b0, 1'b0);
      idle();
      chk("and_alu", aluResult_M, 64'h3C);

      // MUL 6x7 flushed at iteration 10
      drive(1'b0, 1'b1, 4'b1000, 1'b0, '0, '0, 64'd6, 64'd7, 1'b0, 1'b0);
      repeat (10) idle();
      drive(1'b0, 1'b1, 4'b0010, 1'b0, '0, '0, 64'd3, 64'd3, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 4'b0010, 1'b0, '0, '0, 64'd1, 64'd1, 1'b0, 1'b0);
      chk("flush_state", N'({valid_out, busy, ready_out}), 64'b001);
      idle();
      chk("flush_add", aluResult_M, 64'd2);

      // MUL 6x7 with reset at iteration 5
      drive(1'b0, 1'b1, 4'b1000, 1'b0, '0, '0, 64'd6, 64'd7, 1'b0, 1'b0);
      repeat (5) idle();
      drive(1'b1, 1'b0, 4'b0000, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
      idle();
      chk("mrst_flags", N'({valid_out, busy, zero_M}), '0);
      chk("mrst_data", aluResult_M | PCBranch_M | writeData_M, '0);
      repeat (N + 4) idle();
      chk("mrst_quiet", N'(valid_out), '0);

      // randomized traffic
      for (int c = 0; c < 2500; c++) begin
         logic [3:0]   ctl;
         logic [N-1:0] a, b, pc, imm;
         logic         fl, st;
         ctl = ops[$urandom_range(9)];
         a   = {$urandom, $urandom};
         b   = ($urandom_range(7) == 0) ? a : {$urandom, $urandom};
         pc  = {$urandom, $urandom};
         imm = {$urandom, $urandom};
         st  = ($urandom_range(3) == 0);
         fl  = (busy && $urandom_range(60) == 0) || (valid_out && $urandom_range(40) == 0);
         drive(1'b0, ($urandom_range(2) != 0), ctl, 1'(($urandom_range(1))), pc, imm, a, b, st, fl);
      end

      for (int i = 0; i < 200 && (q.size() != 0 || valid_out || busy); i++) idle();
      chk("drain_queue", N'(q.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/execute_pipe.md
# execute_pipe

Registered, parametrised execute stage for the pipelined LEGv8 datapath. It selects the ALU B operand (register or sign-extended immediate) and computes the branch target PC + (imm << 2). Results are latched into an EX/MEM output register with valid/stall/flush control. It also adds an iterative shift-add multiplier (one multiplier bit per cycle) that stalls the stage while it runs.

## Interface
- N, 64, datapath width (≥ 8).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset (already decided).
- valid_in  in  1  upstream presents an instruction this cycle.
- ready_out  out  1  stage accepts this cycle; combinational: !reset && !busy && !(valid_out && stall_in).
- flush  in  1  kill held/in-flight instruction (branch mispredict).
- stall_in  in  1  downstream cannot take the EX/MEM contents.
- AluSrc  in  1  0: B = readData2_E, 1: B = signImm_E.
- AluControl  in  4  operation select (below).
- PC_E, signImm_E, readData1_E, readData2_E  in  N each  operands.
- valid_out  out  1  EX/MEM register holds a valid result.
- PCBranch_M, aluResult_M, writeData_M  out  N each  registered branch target, ALU result, store data (= readData2_E).
- zero_M  out  1  registered (aluResult == 0).
- busy  out  1  multiply iteration in progress.

## Operation
- ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A−B), 0111 pass B, 1100 NOR, 1000 MUL (low N bits of A×B; identical for signed and unsigned). Any other code produces result 0.
- Arithmetic is modulo 2^N. Carries and overflow are discarded.
- PCBranch = PC_E + (signImm_E << 2), truncated to N bits.
- Accept = valid_in && ready_out at a rising edge. Operands and control are sampled only at accept.
- Non-MUL accept: EX/MEM register loads all results and valid_out ← 1 at the same edge.
- MUL accept:
  - Captures A, B, PCBranch and writeData into internal registers; acc ← 0; count ← 0; busy ← 1.
  - EX/MEM register and valid_out ← 0 at that edge.
- MUL iteration (each edge while busy): if B[count] then acc += A << count; count++.
  - On the edge completing count = N−1: EX/MEM loads the final acc, zero and captured fields; valid_out ← 1; busy ← 0.
- Hold: valid_out && stall_in holds every EX/MEM output unchanged. A pending MUL finish also waits (busy stays 1, count frozen at N−1) until stall_in falls.
- valid_out without stall_in and without a new accept: valid_out ← 0 at the next edge (result consumed). Data outputs keep their last values.
- State machine:
  - IDLE: busy=0.
  - MUL: busy=1, iterating.
  - DONE_WAIT: busy=1, finish blocked by stall.
  - IDLE→MUL on MUL accept; MUL→IDLE on final write; MUL→DONE_WAIT on final step while stalled; DONE_WAIT→IDLE when stall_in=0.
- Priority per edge: reset > flush > stall hold > finish/accept.
- Flush: valid_out ← 0, busy ← 0, state ← IDLE. The MUL is abandoned. No accept occurs on a flush edge even if valid_in=1.

## Timing
- Reset: valid_out=0, busy=0, PCBranch_M=aluResult_M=writeData_M=0, zero_M=0, state IDLE, count=0. ready_out=0 while reset=1.
- Reset asserted mid-MUL: at that edge all state returns to reset values and no result is written.
- Non-MUL latency: 1 cycle. Accept at edge k gives results visible after edge k. Throughput is 1 per cycle when stall_in=0.
- MUL latency: N cycles. Accept at edge k → valid_out=1 after edge k+N, with ready_out=0 for edges k+1..k+N. Multiplier bit i is consumed at edge k+1+i (bits 0..N−1 across edges k+1..k+N).
- The next instruction can be accepted at the edge after busy falls.
- stall_in is sampled at each edge. A stall longer than one cycle holds outputs for its full duration.

## Test plan
- Reset, then ADD with A=5, B=readData2=7, AluSrc=0, PC=0x100, imm=3 → after 1 edge: valid_out=1, aluResult_M=12, zero_M=0, PCBranch_M=0x10C, writeData_M=7.
- SUB with A=9, imm=9, AluSrc=1 → aluResult_M=0, zero_M=1. Undefined code 0101 → result 0, zero_M=1.
- MUL with A=0xFFFF_FFFF_FFFF_FFFF, B=3 (N=64) → busy for 64 cycles, ready_out=0. Then aluResult_M=0xFFFF_FFFF_FFFF_FFFD, valid_out=1 exactly 64 edges after accept.
- Back-to-back ADD/OR/AND at 1 per cycle with stall_in=1 for 3 cycles on the second result → outputs held 3 cycles, ready_out=0, no instruction lost or duplicated.
- MUL 6×7 with flush at iteration 10 → valid_out=0, busy=0 next edge, ready_out=1. A following ADD 1+1 gives 2.
- MUL 6×7 with reset pulsed at iteration 5 → all outputs 0, busy=0. No result 42 ever appears.
